nic_ring_port: RTL
==================

# nic_ring_port

Endpoint stage for the NIC ring. It replaces one plain propagation register with a node that does three things:
- removes packets addressed to its node ID and delivers them to a local receive FIFO;
- retires stale, returned and undeliverable packets;
- inserts locally queued transmit packets into empty ring slots.

Ring latency is one cycle, identical to a propagation stage, so nodes and propagation stages can be mixed freely in the ring. Interrupt packets pass through with the same latency and raise a local strobe when addressed here.

## Interface
Parameters:
- TX_DEPTH, 4: transmit FIFO entries (power of two).
- RX_DEPTH, 4: receive FIFO entries (power of two).
- MAX_AGE, 63: age at which a circulating packet is retired; must fit Packet.age.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset; synchronous, active-high.
- id_i  in  6  this node's ID; static while out of reset; 6'h3F is never a node ID.
- packet_i  in  Packet  ring slot from the upstream stage.
- packet_o  out  Packet  ring slot to the downstream stage (registered).
- ipacket_i  in  IPacket  interrupt slot from upstream.
- ipacket_o  out  IPacket  interrupt slot to downstream (registered).
- irq_o  out  1  one-cycle strobe: interrupt packet addressed to this node.
- tx_packet_i  in  Packet  packet to inject; sid and age are overwritten by this block.
- tx_valid_i  in  1  transmit request.
- tx_ready_o  out  1  transmit FIFO not full.
- rx_packet_o  out  Packet  head of the receive FIFO.
- rx_valid_o  out  1  receive FIFO not empty.
- rx_ready_i  in  1  consumer accepts rx_packet_o.
- drop_cnt_o  out  16  saturating count of retired packets.

Packet fields used: typ (PT_NULL means an empty slot), did, sid, age. IPacket fields used: typ, did.

## Operation
Each cycle the incoming slot is classified by the first matching rule. "Forward" means packet_o gets packet_i with age incremented, saturating at MAX_AGE.
1. typ==PT_NULL → slot free.
2. did==id_i:
   - RX FIFO not full → push to RX FIFO, slot free.
   - RX FIFO full → forward (the packet recirculates).
3. sid==id_i → returned own packet (broadcast complete or undeliverable unicast) → retire, slot free.
4. age==MAX_AGE → retire, slot free.
5. did==6'h3F → broadcast:
   - push a copy to the RX FIFO if not full; otherwise the copy is lost and not counted.
   - always forward.
6. Otherwise → forward.

Slot handling:
- Free slot with TX FIFO non-empty → packet_o = TX head with sid=id_i and age=0; TX FIFO pops.
- Free slot with TX FIFO empty → packet_o = all zeros (typ=PT_NULL).
- Retire increments drop_cnt_o, which holds at 16'hFFFF.

FIFO rules:
- TX push when tx_valid_i && tx_ready_o; data beyond that handshake is ignored.
- RX pop when rx_valid_o && rx_ready_i.
- Full/empty are evaluated on the current count. A pop in the same cycle does not make room for a push.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Read and write pointers wrap modulo depth.
- rx_packet_o is the FIFO head; it is stable while rx_valid_o && !rx_ready_i.

Interrupt path:
- ipacket_o <= ipacket_i unconditionally.
- irq_o <= (ipacket_i.typ != PT_NULL && ipacket_i.did == id_i).

## Timing
- Ring latency packet_i→packet_o and ipacket_i→ipacket_o: exactly 1 cycle.
- A TX packet accepted in cycle N can be injected no earlier than cycle N+1's slot, appearing on packet_o at N+2.
- An RX capture in cycle N makes rx_valid_o high at N+1.
- tx_ready_o and rx_valid_o are registered from FIFO counts.
- Reset values:
  - packet_o, ipacket_o, rx_packet_o: all zeros;
  - irq_o, rx_valid_o: 0;
  - tx_ready_o: 1;
  - drop_cnt_o: 0;
  - both FIFOs emptied.
- Reset asserted mid-operation discards FIFO contents and any in-flight slot, with no partial outputs.
- Empty-slot injection and a TX push in the same cycle are legal. The count is updated net of both.

## Test plan
- id_i=5; unicast did=5, sid=2 on packet_i → packet_o PT_NULL next cycle; rx_valid_o=1 one cycle later carrying that packet; drop_cnt_o=0.
- id_i=5; RX FIFO filled with 4 entries, rx_ready_i=0; another did=5 packet arrives with age=3 → forwarded with age=4; RX count stays 4.
- id_i=5; packet did=9, sid=5 arrives → retired, drop_cnt_o=1. Separately, did=9, sid=2, age=63 arrives → retired, drop_cnt_o=2.
- id_i=5; broadcast did=3F, sid=1, age=0 → RX capture and forward with age=1. When it later arrives with sid=5 → retired.
- Queue 3 TX packets, then present 2 empty slots, then 1 non-empty transit slot, then 1 empty slot → injections on slots 1, 2 and 4, each with sid=5 and age=0; the transit packet passes unchanged except for age+1.
- ipacket_i with did=5 → irq_o high for exactly one cycle, ipacket_o matches after 1 cycle. Asserting rst_i mid-stream → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/nic_ring_port.sv
// NIC ring endpoint: same one-cycle latency as a propagation register, plus local
// delivery, retirement of stale/returned packets and insertion of queued transmits.
package nic_ring_pkg;
   typedef enum logic [1:0] {
      PT_NULL = 2'd0,
      PT_DATA = 2'd1,
      PT_CTRL = 2'd2,
      PT_IRQ  = 2'd3
   } ptype_e;

   typedef struct packed {
      ptype_e      typ;
      logic [5:0]  did;
      logic [5:0]  sid;
      logic [5:0]  age;
      logic [31:0] data;
   } packet_t;

   typedef struct packed {
      ptype_e     typ;
      logic [5:0] did;
      logic [7:0] vec;
   } ipacket_t;

   localparam logic [5:0] BCAST_ID = 6'h3F;
endpackage

module nic_ring_port
   import nic_ring_pkg::*;
#(
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4,
   parameter int MAX_AGE  = 63
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [5:0]  id_i,
   input  packet_t     packet_i,
   output packet_t     packet_o,
   input  ipacket_t    ipacket_i,
   output ipacket_t    ipacket_o,
   output logic        irq_o,
   input  packet_t     tx_packet_i,
   input  logic        tx_valid_i,
   output logic        tx_ready_o,
   output packet_t     rx_packet_o,
   output logic        rx_valid_o,
   input  logic        rx_ready_i,
   output logic [15:0] drop_cnt_o
);
   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int TX_CW = TX_AW + 1;
   localparam int RX_CW = RX_AW + 1;

   packet_t            r_tx_mem [TX_DEPTH];
   logic [TX_AW-1:0]   r_tx_wr;
   logic [TX_AW-1:0]   r_tx_rd;
   logic [TX_CW-1:0]   r_tx_cnt;
   logic               r_tx_ready;

   packet_t            r_rx_mem [RX_DEPTH];
   logic [RX_AW-1:0]   r_rx_wr;
   logic [RX_AW-1:0]   r_rx_rd;
   logic [RX_CW-1:0]   r_rx_cnt;
   logic               r_rx_valid;

   packet_t            r_pkt;
   ipacket_t           r_ipkt;
   logic               r_irq;
   logic [15:0]        r_drop;

   logic               w_rx_full;
   logic               w_rx_push;
   logic               w_rx_pop;
   logic               w_tx_push;
   logic               w_tx_pop;
   logic               w_retire;
   logic               w_free;
   logic               w_fwd;
   packet_t            w_fwd_pkt;
   packet_t            w_inj_pkt;
   logic [TX_CW-1:0]   w_tx_cnt_nxt;
   logic [RX_CW-1:0]   w_rx_cnt_nxt;

   // Slot classification: the first matching rule wins.
   always_comb begin
      w_rx_full = (r_rx_cnt == RX_CW'(RX_DEPTH));
      w_rx_pop  = r_rx_valid && rx_ready_i;
      w_tx_push = tx_valid_i && r_tx_ready;
      w_rx_push = 1'b0;
      w_retire  = 1'b0;
      w_free    = 1'b0;
      w_fwd     = 1'b0;
      if (packet_i.typ == PT_NULL) begin
         w_free = 1'b1;
      end else if (packet_i.did == id_i) begin
         if (!w_rx_full) begin
            w_rx_push = 1'b1;
            w_free    = 1'b1;
         end else begin
            w_fwd = 1'b1;
         end
      end else if (packet_i.sid == id_i) begin
         w_retire = 1'b1;
         w_free   = 1'b1;
      end else if (int'(packet_i.age) == MAX_AGE) begin
         w_retire = 1'b1;
         w_free   = 1'b1;
      end else if (packet_i.did == BCAST_ID) begin
         w_rx_push = !w_rx_full;
         w_fwd     = 1'b1;
      end else begin
         w_fwd = 1'b1;
      end
      w_tx_pop = w_free && (r_tx_cnt != '0);

      w_fwd_pkt = packet_i;
      if (int'(packet_i.age) >= MAX_AGE) w_fwd_pkt.age = 6'(MAX_AGE);
      else                               w_fwd_pkt.age = packet_i.age + 6'd1;

      w_inj_pkt     = r_tx_mem[r_tx_rd];
      w_inj_pkt.sid = id_i;
      w_inj_pkt.age = 6'd0;

      case ({w_tx_push, w_tx_pop})
         2'b10:   w_tx_cnt_nxt = r_tx_cnt + TX_CW'(1);
         2'b01:   w_tx_cnt_nxt = r_tx_cnt - TX_CW'(1);
         default: w_tx_cnt_nxt = r_tx_cnt;
      endcase
      case ({w_rx_push, w_rx_pop})
         2'b10:   w_rx_cnt_nxt = r_rx_cnt + RX_CW'(1);
         2'b01:   w_rx_cnt_nxt = r_rx_cnt - RX_CW'(1);
         default: w_rx_cnt_nxt = r_rx_cnt;
      endcase
   end

   // Storage arrays carry no reset; validity is tracked by the counts.
   always_ff @(posedge clk_i) begin
      if (w_tx_push) r_tx_mem[r_tx_wr] <= tx_packet_i;
      if (w_rx_push) r_rx_mem[r_rx_wr] <= packet_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tx_wr    <= '0;
         r_tx_rd    <= '0;
         r_tx_cnt   <= '0;
         r_tx_ready <= 1'b1;
         r_rx_wr    <= '0;
         r_rx_rd    <= '0;
         r_rx_cnt   <= '0;
         r_rx_valid <= 1'b0;
         r_pkt      <= '0;
         r_ipkt     <= '0;
         r_irq      <= 1'b0;
         r_drop     <= '0;
      end else begin
         if (w_tx_push) r_tx_wr <= r_tx_wr + TX_AW'(1);
         if (w_tx_pop)  r_tx_rd <= r_tx_rd + TX_AW'(1);
         r_tx_cnt   <= w_tx_cnt_nxt;
         r_tx_ready <= (w_tx_cnt_nxt != TX_CW'(TX_DEPTH));

         if (w_rx_push) r_rx_wr <= r_rx_wr + RX_AW'(1);
         if (w_rx_pop)  r_rx_rd <= r_rx_rd + RX_AW'(1);
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_rx_valid <= (w_rx_cnt_nxt != '0);

         if (w_fwd)         r_pkt <= w_fwd_pkt;
         else if (w_tx_pop) r_pkt <= w_inj_pkt;
         else               r_pkt <= '0;

         if (w_retire && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;

         r_ipkt <= ipacket_i;
         r_irq  <= (ipacket_i.typ != PT_NULL) && (ipacket_i.did == id_i);
      end
   end

   assign packet_o    = r_pkt;
   assign ipacket_o   = r_ipkt;
   assign irq_o       = r_irq;
   assign tx_ready_o  = r_tx_ready;
   assign rx_valid_o  = r_rx_valid;
   assign rx_packet_o = r_rx_valid ? r_rx_mem[r_rx_rd] : '0;
   assign drop_cnt_o  = r_drop;
endmodule
